weight_ram_loader: RTL and testbench

- Runtime writer for the convolution weight buffers; it is the write-side counterpart of the init-file weight ROM readers (e.g. the 144-bit green-channel weight store).
- Accepts a byte stream from the host/DMA path and packs bytes MSB-first into DATA_WIDTH-bit words.
- Issues one-cycle write strobes to a 2**ADDR_WIDTH-deep simple-dual-port weight RAM at incrementing addresses.
- Reports done, error and a 16-bit byte checksum.

---
 rtl/weight_load_pkg.sv | 19 +
 rtl/weight_ram_loader_if.sv | 25 ++
 rtl/weight_byte_packer.sv | 40 ++++
 rtl/weight_ram_loader.sv | 160 ++++++++++++++++
 tb/tb_weight_ram_loader.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/weight_load_pkg.sv
// Shared types and constants for the runtime weight RAM loader.
package weight_load_pkg;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 144;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_SHORT   = 2'd1;
    localparam logic [1:0] ERR_NO_LAST = 2'd2;

endpackage

// File: rtl/weight_ram_loader_if.sv
// Byte-stream input and weight RAM write port of the loader.
interface weight_ram_loader_if
    import weight_load_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  s_valid;
    logic                  s_ready;
    logic [7:0]            s_data;
    logic                  s_last;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    modport master (
        output s_valid, s_data, s_last,
        input  s_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  s_valid, s_data, s_last,
        output s_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/weight_byte_packer.sv
// Packs bytes MSB-first into a word; the first byte of a word ends up in
// the top byte once the word is complete.
module weight_byte_packer
    import weight_load_pkg::*;
#(
    parameter int BYTES_PER_WORD = DEF_DATA_WIDTH / 8
) (
    input  logic                        clk,
    input  logic                        tb_rst,
    input  logic                        clear,
    input  logic                        shift_en,
    input  logic [7:0]                  byte_in,
    output logic [BYTES_PER_WORD*8-1:0] word,
    output logic                        word_full
);
    localparam int WORD_WIDTH = BYTES_PER_WORD * 8;
    localparam int CNT_WIDTH  = $clog2(BYTES_PER_WORD + 1);

    logic [CNT_WIDTH-1:0] byte_cnt;

    // High while the byte that completes the current word is being accepted.
    assign word_full = shift_en && (byte_cnt == CNT_WIDTH'(BYTES_PER_WORD - 1));

    // Shift register and byte counter; clear only restarts the count.
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            word     <= '0;
            byte_cnt <= '0;
        end else if (clear) begin
            word     <= word;
            byte_cnt <= '0;
        end else if (shift_en) begin
            word     <= {word[WORD_WIDTH-9:0], byte_in};
            byte_cnt <= byte_cnt + CNT_WIDTH'(1'b1);
        end else begin
            word     <= word;
            byte_cnt <= byte_cnt;
        end
    end
endmodule

// File: rtl/weight_ram_loader.sv
// Runtime writer for the convolution weight RAM: packs a byte stream into
// words, writes them at incrementing addresses and reports done/error status
// together with a 16-bit byte checksum.
module weight_ram_loader
    import weight_load_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic               clk,
    input  logic               tb_rst,
    input  logic               start,
    weight_ram_loader_if.slave bus,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [1:0]         err_code,
    output logic [15:0]        checksum
);
    localparam int BYTES_PER_WORD = DATA_WIDTH / 8;

    state_t                state;
    state_t                next_state;
    logic [1:0]            next_code;
    logic                  arm;
    logic                  ready;
    logic                  write_strobe;
    logic                  accept;
    logic                  word_full;
    logic                  last_word;
    logic                  final_byte;
    logic                  missing_last;
    logic                  packer_clear;
    logic [ADDR_WIDTH-1:0] word_cnt;
    logic [DATA_WIDTH-1:0] packed_word;

    assign accept       = bus.s_valid && ready;
    assign last_word    = (word_cnt == {ADDR_WIDTH{1'b1}});
    assign final_byte   = word_full && last_word;
    assign packer_clear = arm || (state == WRITE);

    assign bus.s_ready = ready;
    assign bus.wr_en   = write_strobe;
    assign bus.wr_addr = word_cnt;
    assign bus.wr_data = packed_word;

    weight_byte_packer #(
        .BYTES_PER_WORD(BYTES_PER_WORD)
    ) u_packer (
        .clk      (clk),
        .tb_rst   (tb_rst),
        .clear    (packer_clear),
        .shift_en (accept),
        .byte_in  (bus.s_data),
        .word     (packed_word),
        .word_full(word_full)
    );

    // Next-state, error code and load-arm decode.
    always_comb begin
        next_state = state;
        next_code  = err_code;
        arm        = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    next_state = LOAD;
                    next_code  = ERR_NONE;
                    arm        = 1'b1;
                end else begin
                    next_state = state;
                end
            end
            LOAD: begin
                if (accept && bus.s_last && !final_byte) begin
                    next_state = ERR;
                    next_code  = ERR_SHORT;
                end else if (word_full) begin
                    next_state = WRITE;
                end else begin
                    next_state = LOAD;
                end
            end
            WRITE: begin
                if (last_word && missing_last) begin
                    next_state = ERR;
                    next_code  = ERR_NO_LAST;
                end else if (last_word) begin
                    next_state = DONE;
                end else begin
                    next_state = LOAD;
                end
            end
            default: begin
                next_state = IDLE;
                next_code  = ERR_NONE;
            end
        endcase
    end

    // State register with status and handshake outputs registered from the next state.
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            state        <= IDLE;
            ready        <= 1'b0;
            write_strobe <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            err_code     <= ERR_NONE;
        end else begin
            state        <= next_state;
            ready        <= (next_state == LOAD);
            write_strobe <= (next_state == WRITE);
            busy         <= (next_state == LOAD) || (next_state == WRITE);
            done         <= (next_state == DONE);
            err          <= (next_state == ERR);
            err_code     <= next_code;
        end
    end

    // Word address counter; stops at the last word instead of wrapping.
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            word_cnt <= '0;
        end else if (arm) begin
            word_cnt <= '0;
        end else if ((state == WRITE) && !last_word) begin
            word_cnt <= word_cnt + ADDR_WIDTH'(1'b1);
        end else begin
            word_cnt <= word_cnt;
        end
    end

    // Running checksum over every accepted byte, discarded words included.
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            checksum <= 16'h0000;
        end else if (arm) begin
            checksum <= 16'h0000;
        end else if (accept) begin
            checksum <= checksum + {8'h00, bus.s_data};
        end else begin
            checksum <= checksum;
        end
    end

    // Remembers that the final byte of the image arrived without s_last.
    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            missing_last <= 1'b0;
        end else if (arm) begin
            missing_last <= 1'b0;
        end else if (accept && word_full) begin
            missing_last <= last_word && !bus.s_last;
        end else begin
            missing_last <= missing_last;
        end
    end
endmodule

// File: tb/tb_weight_ram_loader.sv
// Randomised self-checking bench for weight_ram_loader against an
// image-level reference model.
module tb_weight_ram_loader;
    localparam int AW     = 8;
    localparam int DW     = 144;
    localparam int BPW    = DW / 8;
    localparam int NWORDS = 1 << AW;
    localparam int NBYTES = NWORDS * BPW;

    logic        clk    = 1'b0;
    logic        tb_rst = 1'b1;
    logic        start  = 1'b0;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  err_code;
    logic [15:0] checksum;

    weight_ram_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    weight_ram_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk     (clk),
        .tb_rst  (tb_rst),
        .start   (start),
        .bus     (bus.slave),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .err_code(err_code),
        .checksum(checksum)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int acc_first    = 0;
    int acc_word0    = 0;

    logic [7:0]    img [NBYTES];
    logic [AW-1:0] mon_addr [$];
    logic [DW-1:0] mon_data [$];
    int            mon_cyc  [$];

    logic [DW-1:0] exp_data [$];
    int            exp_writes;
    logic          exp_done;
    logic          exp_err;
    logic [1:0]    exp_code;
    logic [15:0]   exp_sum;

    // Free-running cycle counter.
    always @(posedge clk) cyc <= cyc + 1;

    // Capture every RAM write strobe.
    always @(negedge clk) begin
        if (bus.wr_en) begin
            mon_addr.push_back(bus.wr_addr);
            mon_data.push_back(bus.wr_data);
            mon_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: what an image of n bytes with s_last at last_pos (-1 = none) must produce.
    function automatic void build_model(input int n, input int last_pos);
        int            nacc;
        logic [DW-1:0] w;
        exp_data.delete();
        exp_sum = 16'h0000;
        if (last_pos >= 0 && last_pos != NBYTES - 1) begin
            nacc       = last_pos + 1;
            exp_writes = last_pos / BPW;
            exp_done   = 1'b0;
            exp_err    = 1'b1;
            exp_code   = 2'd1;
        end else begin
            nacc       = n;
            exp_writes = n / BPW;
            exp_done   = (last_pos == NBYTES - 1);
            exp_err    = (last_pos != NBYTES - 1);
            exp_code   = (last_pos == NBYTES - 1) ? 2'd0 : 2'd2;
        end
        for (int a = 0; a < nacc; a++) exp_sum = exp_sum + 16'(img[a]);
        for (int k = 0; k < exp_writes; k++) begin
            w = '0;
            for (int b = 0; b < BPW; b++) w[DW - 1 - 8 * b -: 8] = img[k * BPW + b];
            exp_data.push_back(w);
        end
    endfunction

    task automatic start_load();
        mon_addr.delete();
        mon_data.delete();
        mon_cyc.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_flags", {done, err, err_code}, 0);
        check("start_sum", checksum, 0);
    endtask

    task automatic drive_bytes(input int n, input int last_pos, input bit gaps);
        int i      = 0;
        int budget = n * 4 + 200;
        while (i < n && budget > 0) begin
            @(negedge clk);
            budget--;
            if (gaps && $urandom_range(0, 1) == 0) begin
                bus.s_valid = 1'b0;
                bus.s_data  = 8'($urandom);
                bus.s_last  = 1'($urandom);
            end else begin
                bus.s_valid = 1'b1;
                bus.s_data  = img[i];
                bus.s_last  = (i == last_pos);
                if (bus.s_ready) begin
                    if (i == 0) acc_first = cyc;
                    if (i == BPW - 1) acc_word0 = cyc;
                    i++;
                end
            end
        end
        if (i < n) check("drive_timeout", i, n);
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic wait_end();
        int k = 0;
        while (!(done || err) && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("end_reached", done || err, 1);
    endtask

    task automatic check_results(input string t);
        int nchk;
        check({t, "_n_writes"}, mon_data.size(), exp_writes);
        nchk = (mon_data.size() < exp_writes) ? mon_data.size() : exp_writes;
        for (int k = 0; k < nchk; k++) begin
            check($sformatf("%s_addr[%0d]", t, k), mon_addr[k], k);
            check($sformatf("%s_data[%0d]", t, k), mon_data[k], exp_data[k]);
        end
        check({t, "_done"}, done, exp_done);
        check({t, "_err"}, err, exp_err);
        check({t, "_err_code"}, err_code, exp_code);
        check({t, "_checksum"}, checksum, exp_sum);
        check({t, "_idle_hs"}, {bus.s_ready, busy, bus.wr_en}, 0);
    endtask

    task automatic check_reset_outs(input string t);
        check({t, "_flags"}, {bus.s_ready, bus.wr_en, busy, done, err, err_code, checksum, bus.wr_addr}, 0);
        check({t, "_wr_data"}, bus.wr_data, 0);
    endtask

    task automatic fill_random();
        for (int a = 0; a < NBYTES; a++) img[a] = 8'($urandom);
    endtask

    initial begin
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        bus.s_last  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outs("reset");
        tb_rst = 1'b0;
        @(negedge clk);
        check("idle_ready", {bus.s_ready, busy}, 0);

        // Full image of 0xFF, no gaps.
        for (int a = 0; a < NBYTES; a++) img[a] = 8'hFF;
        build_model(NBYTES, NBYTES - 1);
        start_load();
        drive_bytes(NBYTES, NBYTES - 1, 1'b0);
        wait_end();
        check_results("ones");
        check("ones_sum_const", checksum, 16'hEE00);
        if (mon_cyc.size() > 0)
            check("ones_cycles", mon_cyc[mon_cyc.size() - 1] - acc_first + 1, NWORDS * (BPW + 1));

        // Short frame: first word 0x01..0x12, s_last on byte 59.
        fill_random();
        for (int a = 0; a < BPW; a++) img[a] = 8'(a + 1);
        build_model(59, 58);
        start_load();
        drive_bytes(59, 58, 1'b0);
        wait_end();
        check_results("short");
        if (mon_cyc.size() > 0) begin
            check("short_word0", mon_data[0], 144'h0102030405060708090a0b0c0d0e0f101112);
            check("short_wr_latency", mon_cyc[0], acc_word0 + 1);
        end

        // Full random image, s_last never asserted.
        fill_random();
        build_model(NBYTES, -1);
        start_load();
        drive_bytes(NBYTES, -1, 1'b0);
        wait_end();
        check_results("nolast");

        // Same image with random valid gaps and a proper s_last.
        build_model(NBYTES, NBYTES - 1);
        start_load();
        drive_bytes(NBYTES, NBYTES - 1, 1'b1);
        wait_end();
        check_results("gaps");

        // Reset in the middle of a load, then a fresh full image.
        fill_random();
        start_load();
        drive_bytes(100, -1, 1'b0);
        check("midload_busy", busy, 1);
        tb_rst = 1'b1;
        #1;
        check_reset_outs("midrst_a");
        repeat (2) @(negedge clk);
        check_reset_outs("midrst_b");
        tb_rst = 1'b0;
        fill_random();
        build_model(NBYTES, NBYTES - 1);
        start_load();
        drive_bytes(NBYTES, NBYTES - 1, 1'b0);
        wait_end();
        check_results("afterrst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
